apb_slave_mem: RTL

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_regfile.sv | 40 ++++
 rtl/apb_slave_mem.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg: definitions shared by the APB completer and the bridge.
//   apb_state_e  - completer FSM states (IDLE / WAIT / DONE)
//   APB_WORD_LSB - byte-address bit where the word index starts
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int unsigned APB_WORD_LSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// ---------------------------------------------------------------------------
// apb_regfile: DEPTH x DATA_WIDTH register array.
// The array has one synchronous write port and one combinational read port.
// All words clear on reset.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   i_we             - write enable
//   i_waddr, i_wdata - write index and data
//   i_raddr, o_rdata - read index and combinational read data
// ---------------------------------------------------------------------------
module apb_regfile
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]      o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_mem: APB3 completer backed by a DEPTH-word register file.
// Each transfer inserts WAIT_CYCLES wait states (0..15).
// Optional feature: define APB_SLV_ERR_EN to drive pslverr on out-of-range
// accesses. Otherwise pslverr is tied low.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   psel, penable, pwrite        - APB control
//   paddr, pwdata                - byte address, write data
//   pready, prdata, pslverr      - registered completer response
// ---------------------------------------------------------------------------
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned HI_LSB    = APB_WORD_LSB + IDX_W;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    apb_state_e            r_state;
    logic [3:0]            r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_write;
    logic                  r_in_range;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_pready;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_pslverr;

    logic                  w_in_range;
    logic                  w_we;
    logic                  w_cur_write;
    logic                  w_cur_in_range;
    logic [IDX_W-1:0]      w_cur_idx;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [DATA_WIDTH-1:0] w_done_rdata;
    logic                  w_done_err;

    // DEPTH is a power of two, so "paddr < 4*DEPTH" means all bits above the index are zero.
    assign w_in_range = ((paddr >> HI_LSB) == '0) && (paddr[APB_WORD_LSB-1:0] == '0);

    // In IDLE, DONE can be entered straight from the setup phase (WAIT_CYCLES=0).
    // The response is therefore built from the live bus in IDLE and from the
    // latched copy otherwise.
    assign w_cur_write    = (r_state == IDLE) ? pwrite     : r_write;
    assign w_cur_in_range = (r_state == IDLE) ? w_in_range : r_in_range;
    assign w_cur_idx      = (r_state == IDLE) ? paddr[APB_WORD_LSB +: IDX_W] : r_idx;

    assign w_done_rdata = (w_cur_in_range && !w_cur_write) ? w_rdata : '0;
`ifdef APB_SLV_ERR_EN
    assign w_done_err = !w_cur_in_range;
`else
    assign w_done_err = 1'b0;
`endif

    // Commit only on the completing edge of an in-range write.
    assign w_we = (r_state == DONE) && psel && penable && r_write && r_in_range;

    apb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_raddr (w_cur_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_write    <= 1'b0;
            r_in_range <= 1'b0;
            r_wdata    <= '0;
            r_pready   <= 1'b0;
            r_prdata   <= '0;
            r_pslverr  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pready  <= 1'b0;
                    r_prdata  <= '0;
                    r_pslverr <= 1'b0;
                    // A lone penable without a setup phase is ignored.
                    if (psel && !penable) begin
                        r_idx      <= paddr[APB_WORD_LSB +: IDX_W];
                        r_write    <= pwrite;
                        r_in_range <= w_in_range;
                        r_wdata    <= pwdata;
                        r_cnt      <= WAIT_INIT;
                        if (WAIT_CYCLES == 0) begin
                            r_state   <= DONE;
                            r_pready  <= 1'b1;
                            r_prdata  <= w_done_rdata;
                            r_pslverr <= w_done_err;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (penable) begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state   <= DONE;
                            r_pready  <= 1'b1;
                            r_prdata  <= w_done_rdata;
                            r_pslverr <= w_done_err;
                        end
                    end
                end
                DONE: begin
                    // Always leave after one cycle. Dropping psel here simply skips the write.
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_pready  <= 1'b0;
                    r_prdata  <= '0;
                    r_pslverr <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pready  = r_pready;
    assign prdata  = r_prdata;
    assign pslverr = r_pslverr;

endmodule
